// File: rtl/preadder_pipe_if.sv
// preadder_pipe_if: operand, control and result signals of the pre-adder pipeline.
interface preadder_pipe_if #(parameter int WIDTH = 25);
    logic                    CED;
    logic                    CEAD;
    logic signed [WIDTH-1:0] D;
    logic signed [WIDTH-1:0] AMULT_REGA;
    logic [2:0]              INMODE;
    logic                    IN_VALID;
    logic                    CLR_OVF;
    logic signed [WIDTH-1:0] AMULT;
    logic                    OUT_VALID;
    logic                    OVF;
    logic                    OVF_STICKY;
    modport master (output CED, CEAD, D, AMULT_REGA, INMODE, IN_VALID, CLR_OVF,
                    input  AMULT, OUT_VALID, OVF, OVF_STICKY);
    modport slave  (input  CED, CEAD, D, AMULT_REGA, INMODE, IN_VALID, CLR_OVF,
                    output AMULT, OUT_VALID, OVF, OVF_STICKY);
endinterface

// File: rtl/preadder_pipe.sv
// preadder_pipe: D delay line, saturating/wrapping pre-adder and AD pipeline feeding the multiplier A side.
module preadder_pipe #(
    parameter int WIDTH     = 25,
    parameter int DREG      = 1,
    parameter int ADREG     = 1,
    parameter int USE_DPORT = 0,
    parameter int SATURATE  = 0
) (
    input logic clk,
    input logic RST,
    preadder_pipe_if.slave io
);
    localparam int AW = WIDTH + 2;
    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam bit DP = USE_DPORT != 0;

    logic [WIDTH:0]          d_out;
    logic signed [WIDTH:0]   a_x, d_x, a_sel, p_full;
    logic                    p_ovf;
    logic signed [WIDTH-1:0] p_val;
    logic [AW-1:0]           ad_in, ad_out;
    logic signed [WIDTH-1:0] ad_p;
    logic                    ad_ovf, ad_v, ovf_o, v_o;
    logic                    sticky_q, sticky_d;

    // Valid rides as the MSB of each D stage word.
    generate
        if (DREG > 0) begin : g_d
            logic [WIDTH:0] d_q [DREG];
            logic [WIDTH:0] d_d [DREG];
            always_comb begin
                d_d = d_q;
                if (DP && io.CED) begin
                    d_d[0] = {io.IN_VALID, io.D};
                    for (int i = 1; i < DREG; i++) d_d[i] = d_q[i-1];
                end
            end
            always_ff @(posedge clk or posedge RST)
                if (RST) for (int i = 0; i < DREG; i++) d_q[i] <= '0;
                else     d_q <= d_d;
            assign d_out = d_q[DREG-1];
        end else begin : g_nd
            assign d_out = {io.IN_VALID, io.D};
        end
    endgenerate

    always_comb begin
        a_x    = {io.AMULT_REGA[WIDTH-1], io.AMULT_REGA};
        d_x    = {d_out[WIDTH-1], d_out[WIDTH-1:0]};
        a_sel  = io.INMODE[2] ? -a_x : a_x;
        p_full = io.INMODE[0] ? (io.INMODE[1] ? d_x : '0) : (io.INMODE[1] ? d_x + a_sel : a_sel);
        p_ovf  = p_full[WIDTH] ^ p_full[WIDTH-1];
        p_val  = (p_ovf && SATURATE != 0) ? (p_full[WIDTH] ? MINV : MAXV) : p_full[WIDTH-1:0];
        ad_in  = {d_out[WIDTH], p_ovf, p_val};
    end

    generate
        if (ADREG > 0) begin : g_ad
            logic [AW-1:0] ad_q [ADREG];
            logic [AW-1:0] ad_d [ADREG];
            always_comb begin
                ad_d = ad_q;
                if (DP && io.CEAD) begin
                    ad_d[0] = ad_in;
                    for (int i = 1; i < ADREG; i++) ad_d[i] = ad_q[i-1];
                end
            end
            always_ff @(posedge clk or posedge RST)
                if (RST) for (int i = 0; i < ADREG; i++) ad_q[i] <= '0;
                else     ad_q <= ad_d;
            assign ad_out = ad_q[ADREG-1];
        end else begin : g_nad
            assign ad_out = ad_in;
        end
    endgenerate

    always_comb begin
        ad_p     = ad_out[WIDTH-1:0];
        ad_ovf   = ad_out[WIDTH];
        ad_v     = ad_out[WIDTH+1];
        v_o      = DP ? ad_v : io.IN_VALID;
        ovf_o    = DP ? (ad_ovf & ad_v) : 1'b0;
        sticky_d = (ovf_o && v_o) ? 1'b1 : (io.CLR_OVF ? 1'b0 : sticky_q);
    end

    always_ff @(posedge clk or posedge RST)
        if (RST) sticky_q <= 1'b0;
        else     sticky_q <= sticky_d;

    assign io.AMULT      = DP ? ad_p : (io.INMODE[0] ? '0 : io.AMULT_REGA);
    assign io.OUT_VALID  = v_o;
    assign io.OVF        = ovf_o;
    assign io.OVF_STICKY = sticky_q;
endmodule

// File: tb/tb_preadder_pipe.sv
// tb_preadder_pipe: scoreboard bench for saturating, wrapping and bypass instances of preadder_pipe.
module tb_preadder_pipe;
    localparam int W = 25;
    localparam longint MAXL = (64'sd1 <<< (W-1)) - 1;
    localparam longint MINL = -(64'sd1 <<< (W-1));

    typedef struct {
        logic signed [W-1:0] s;
        logic signed [W-1:0] w;
        logic                o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ced, cead, in_valid, clr_ovf;
    logic signed [W-1:0] d, a;
    logic [2:0] inmode;
    int total = 0;
    int bad = 0;

    exp_t q[$];
    logic signed [W-1:0] md, cur_s, cur_w;
    logic mdv, cur_v, cur_o, msticky;

    always #5 clk = ~clk;

    preadder_pipe_if #(.WIDTH(W)) if_s ();
    preadder_pipe_if #(.WIDTH(W)) if_w ();
    preadder_pipe_if #(.WIDTH(W)) if_b ();

    assign if_s.CED = ced; assign if_s.CEAD = cead; assign if_s.D = d; assign if_s.AMULT_REGA = a;
    assign if_s.INMODE = inmode; assign if_s.IN_VALID = in_valid; assign if_s.CLR_OVF = clr_ovf;
    assign if_w.CED = ced; assign if_w.CEAD = cead; assign if_w.D = d; assign if_w.AMULT_REGA = a;
    assign if_w.INMODE = inmode; assign if_w.IN_VALID = in_valid; assign if_w.CLR_OVF = clr_ovf;
    assign if_b.CED = ced; assign if_b.CEAD = cead; assign if_b.D = d; assign if_b.AMULT_REGA = a;
    assign if_b.INMODE = inmode; assign if_b.IN_VALID = in_valid; assign if_b.CLR_OVF = clr_ovf;

    preadder_pipe #(.WIDTH(W), .DREG(1), .ADREG(1), .USE_DPORT(1), .SATURATE(1))
        u_sat (.clk(clk), .RST(rst), .io(if_s));
    preadder_pipe #(.WIDTH(W), .DREG(1), .ADREG(1), .USE_DPORT(1), .SATURATE(0))
        u_wrap (.clk(clk), .RST(rst), .io(if_w));
    preadder_pipe #(.WIDTH(W), .DREG(1), .ADREG(1), .USE_DPORT(0), .SATURATE(0))
        u_byp (.clk(clk), .RST(rst), .io(if_b));

    task automatic check(input string tag, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic exp_t pre(input logic signed [W-1:0] dv, input logic signed [W-1:0] av,
                                 input logic [2:0] m);
        exp_t e;
        longint x, xa, xd;
        xa = av;
        xd = dv;
        case (m)
            3'd0:       x = xa;
            3'd2:       x = xd + xa;
            3'd3, 3'd7: x = xd;
            3'd4:       x = -xa;
            3'd6:       x = xd - xa;
            default:    x = 0;
        endcase
        e.w = x[W-1:0];
        e.o = (x > MAXL) || (x < MINL);
        if (e.o) x = (x > 0) ? MAXL : MINL;
        e.s = x[W-1:0];
        return e;
    endfunction

    task automatic model_clear();
        q.delete();
        mdv = 0; cur_v = 0; cur_o = 0; msticky = 0; md = '0; cur_s = '0; cur_w = '0;
    endtask

    task automatic step(input logic cd, input logic ca, input logic signed [W-1:0] dv,
                        input logic signed [W-1:0] av, input logic [2:0] m,
                        input logic iv, input logic clr);
        exp_t e;
        bit pushed;
        ced = cd; cead = ca; d = dv; a = av; inmode = m; in_valid = iv; clr_ovf = clr;
        @(posedge clk);
        pushed = 0;
        if (ca && mdv) begin
            q.push_back(pre(md, av, m));
            pushed = 1;
        end
        if (cur_v && cur_o) msticky = 1;
        else if (clr)       msticky = 0;
        if (cd) begin md = dv; mdv = iv; end
        #1;
        if (ca) begin
            if (pushed) begin
                e = q.pop_front();
                cur_v = 1; cur_o = e.o; cur_s = e.s; cur_w = e.w;
            end else begin
                cur_v = 0; cur_o = 0;
            end
        end
        check("valid_sat", if_s.OUT_VALID, cur_v);
        check("valid_wrap", if_w.OUT_VALID, cur_v);
        check("ovf_sat", if_s.OVF, cur_o);
        check("ovf_wrap", if_w.OVF, cur_o);
        if (cur_v) begin
            check("amult_sat", if_s.AMULT, cur_s);
            check("amult_wrap", if_w.AMULT, cur_w);
        end
        check("sticky", if_s.OVF_STICKY, msticky);
    endtask

    task automatic pulse_rst();
        #2 rst = 1;
        #1;
        check("rst_amult", if_s.AMULT, 0);
        check("rst_valid", if_s.OUT_VALID, 0);
        check("rst_ovf", if_s.OVF, 0);
        check("rst_sticky", if_s.OVF_STICKY, 0);
        check("rst_valid_wrap", if_w.OUT_VALID, 0);
        rst = 0;
        model_clear();
    endtask

    initial begin
        logic signed [W-1:0] rd, ra;
        rst = 1; ced = 0; cead = 0; d = '0; a = '0; inmode = '0; in_valid = 0; clr_ovf = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_amult", if_s.AMULT, 0);
        check("reset_valid", if_s.OUT_VALID, 0);
        check("reset_ovf", if_s.OVF, 0);
        check("reset_sticky", if_s.OVF_STICKY, 0);
        rst = 0;
        step(1, 1, 100, 23, 3'b010, 1, 0);
        step(1, 1, 0, 23, 3'b010, 0, 0);
        check("basic_123", if_s.AMULT, 123);
        step(1, 1, 0, 0, 3'b000, 0, 0);
        step(1, 1, 25'sd16777215, 1, 3'b010, 1, 0);
        step(1, 1, 0, 1, 3'b010, 0, 0);
        check("pos_sat", if_s.AMULT, 16777215);
        check("pos_wrap", if_w.AMULT, -16777216);
        step(1, 0, 0, 1, 3'b010, 0, 1);
        check("clr_vs_set", if_s.OVF_STICKY, 1);
        step(1, 1, 5, 25'sh1000000, 3'b100, 1, 0);
        step(1, 1, 25'sh1000000, 25'sh1000000, 3'b100, 1, 0);
        check("neg_a_sat", if_s.AMULT, 16777215);
        step(1, 1, 0, 1, 3'b110, 0, 0);
        check("d_minus_a_sat", if_s.AMULT, -16777216);
        step(1, 1, 0, 0, 3'b000, 0, 0);
        step(1, 1, 0, 0, 3'b000, 0, 1);
        check("sticky_cleared", if_s.OVF_STICKY, 0);
        step(1, 1, 10, 5, 3'b010, 1, 0);
        step(1, 1, 20, 5, 3'b010, 1, 0);
        step(1, 0, 30, 5, 3'b010, 1, 0);
        step(1, 0, 40, 5, 3'b010, 1, 0);
        step(1, 0, 50, 5, 3'b010, 1, 0);
        check("stall_hold", if_s.AMULT, 15);
        step(1, 1, 60, 5, 3'b010, 0, 0);
        check("stall_resume", if_s.AMULT, 55);
        step(1, 1, 0, 5, 3'b010, 0, 0);
        step(1, 1, 7, 3, 3'b010, 1, 0);
        pulse_rst();
        step(1, 1, 200, 1, 3'b110, 1, 0);
        step(1, 1, 0, 1, 3'b110, 0, 0);
        check("post_rst", if_s.AMULT, 199);
        for (int i = 0; i < 80; i++) begin
            rd = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 25'sh0FFFFFF : 25'sh1000000)
                                              : W'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 25'sh0FFFFFF : 25'sh1000000)
                                              : W'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd, ra, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
        end
        ced = 1; cead = 1; a = 55; inmode = 3'b001; in_valid = 1; clr_ovf = 0;
        #1;
        check("byp_zero", if_b.AMULT, 0);
        check("byp_valid", if_b.OUT_VALID, 1);
        inmode = 3'b000;
        #1;
        check("byp_a", if_b.AMULT, 55);
        check("byp_ovf", if_b.OVF, 0);
        check("byp_sticky", if_b.OVF_STICKY, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
